// File: rtl/spi_mram_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// spi_mram_cmd_ctrl
//
// Command sequencer between the SPI slave word interface and the MRAM access
// port. Each 16-bit SPI word is decoded as {opcode[1:0], address[13:0]}:
//   00 NOP     - ignored
//   01 WRITE   - next SPI word is the write data, then one memory write
//   10 READ    - one memory read, read data returned on the SPI transmit path
//   11 STATUS  - returns {8'hA5, 6'b0, err_proto, err_timeout} and clears both
// Memory accesses use a req/ack handshake guarded by a timeout counter. This
// block is the only master of the memory port.
//
// Ports
//   FPGA_clk     in   system clock, rising edge
//   FPGA_rst     in   asynchronous active-low reset
//   ssel_active  in   SPI frame active (already in the FPGA_clk domain)
//   rx_valid     in   one-cycle strobe, rx_data holds a new SPI word
//   rx_data      in   received SPI word
//   tx_data      out  word for the next SPI transfer, held until the next load
//   tx_load      out  one-cycle strobe, tx_data is new
//   mem_req      out  memory request, held until mem_ack or timeout
//   mem_we       out  1 = write, 0 = read; valid while mem_req
//   mem_addr     out  memory address; valid while mem_req
//   mem_wdata    out  write data; valid while mem_req && mem_we
//   mem_ack      in   one-cycle completion strobe, mem_rdata valid with it
//   mem_rdata    in   read data
//   busy         out  high whenever the sequencer is not idle
//   err          out  OR of the sticky timeout and protocol error flags
// -----------------------------------------------------------------------------
module spi_mram_cmd_ctrl #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              FPGA_clk,
    input  logic              FPGA_rst,
    input  logic              ssel_active,
    input  logic              rx_valid,
    input  logic [15:0]       rx_data,
    output logic [15:0]       tx_data,
    output logic              tx_load,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_MEM_WR,
        S_MEM_RD,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_WRITE  = 2'b01,
        OP_READ   = 2'b10,
        OP_STATUS = 2'b11
    } opcode_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [15:0]       r_tx_data;
    logic              r_tx_load;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic              r_err_timeout;
    logic              r_err_proto;
    logic [TO_W-1:0]   r_to_cnt;
    // Frame ended while a memory access was in flight: finish the handshake
    // but do not return read data.
    logic              r_drop;

    opcode_t           w_opcode;
    logic              w_drop_now;

    assign w_opcode   = opcode_t'(rx_data[15:14]);
    assign w_drop_now = r_drop || !ssel_active;

    assign tx_data   = r_tx_data;
    assign tx_load   = r_tx_load;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err_timeout | r_err_proto;

    // NOTE: all state is updated with non-blocking assignments so every
    // branch below reads the values from before this clock edge.
    always_ff @(posedge FPGA_clk or negedge FPGA_rst) begin
        if (!FPGA_rst) begin
            r_state       <= S_IDLE;
            r_tx_data     <= 16'h0000;
            r_tx_load     <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= 16'h0000;
            r_err_timeout <= 1'b0;
            r_err_proto   <= 1'b0;
            r_to_cnt      <= '0;
            r_drop        <= 1'b0;
        end else begin
            // NOTE: strobe defaults low every cycle; only the loading branch
            // raises it, which makes it a single-cycle pulse by construction.
            r_tx_load <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        case (w_opcode)
                            OP_NOP: begin
                            end
                            OP_WRITE: begin
                                r_mem_addr <= rx_data[ADDR_W-1:0];
                                // Frame ending with the command word leaves
                                // no way to receive data: treat as aborted.
                                if (ssel_active) begin
                                    r_state <= S_WAIT_DATA;
                                end else begin
                                    r_err_proto <= 1'b1;
                                end
                            end
                            OP_READ: begin
                                r_mem_addr <= rx_data[ADDR_W-1:0];
                                r_mem_we   <= 1'b0;
                                r_mem_req  <= 1'b1;
                                r_to_cnt   <= '0;
                                r_drop     <= !ssel_active;
                                r_state    <= S_MEM_RD;
                            end
                            OP_STATUS: begin
                                r_tx_data     <= {8'hA5, 6'b0, r_err_proto, r_err_timeout};
                                r_tx_load     <= 1'b1;
                                r_err_proto   <= 1'b0;
                                r_err_timeout <= 1'b0;
                                r_state       <= S_RESP;
                            end
                        endcase
                    end
                end

                S_WAIT_DATA: begin
                    // A data word wins over a simultaneous frame end.
                    if (rx_valid) begin
                        r_mem_wdata <= rx_data;
                        r_mem_we    <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_to_cnt    <= '0;
                        r_drop      <= !ssel_active;
                        r_state     <= S_MEM_WR;
                    end else if (!ssel_active) begin
                        r_err_proto <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                S_MEM_WR, S_MEM_RD: begin
                    if (rx_valid) begin
                        r_err_proto <= 1'b1;
                    end
                    if (!ssel_active) begin
                        r_drop <= 1'b1;
                    end
                    // Ack is checked first so an ack on the final timeout
                    // cycle completes normally.
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_to_cnt  <= '0;
                        if (r_state == S_MEM_RD && !w_drop_now) begin
                            r_tx_data <= mem_rdata;
                            r_tx_load <= 1'b1;
                            r_state   <= S_RESP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_mem_req     <= 1'b0;
                        r_to_cnt      <= '0;
                        r_err_timeout <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (rx_valid) begin
                        r_err_proto <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
